// File: rtl/seq_alu.sv
// Registered ALU with a valid/ready handshake on both sides.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier for opcode 0011.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SRA  = 4'b1110;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    count_r;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t           state_r;
  state_t           next_state_s;
  logic             is_mul_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic [SHW-1:0]   shamt_s;

  assign shamt_s  = b[SHW-1:0];
  assign in_ready = rst_n && (state_r == IDLE);

`ifdef SEQ_ALU_MUL_EN
  assign is_mul_s = (alu_control == OP_MUL);
`else
  assign is_mul_s = 1'b0;
`endif

  // Single-cycle datapath, evaluated straight from the accepted operands.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    case (alu_control)
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_ADD:  {carry_s, res_s} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        res_s   = a - b;
        carry_s = (a >= b);
      end
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  res_s = a ^ b;
      OP_NOR:  res_s = ~(a | b);
      OP_SLL:  res_s = a << shamt_s;
      OP_SRL:  res_s = a >> shamt_s;
      OP_SRA:  res_s = $signed(a) >>> shamt_s;
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
      end
    endcase
  end

  // Next-state logic for the IDLE/BUSY/DONE handshake sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          next_state_s = is_mul_s ? state_t'(2'd1) : DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      // One extra BUSY cycle after the last bit so the result lands WIDTH+1 edges after accept.
      BUSY: begin
        if (count_r == CW'(WIDTH)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = BUSY;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, result/flag and multiplier registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      negative  <= 1'b0;
      carry     <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand_r   <= {WIDTH{1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
`endif
    end else begin
      state_r   <= next_state_s;
      out_valid <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid && !is_mul_s) begin
            result   <= res_s;
            zero     <= (res_s == {WIDTH{1'b0}});
            negative <= res_s[WIDTH-1];
            carry    <= carry_s;
          end
`ifdef SEQ_ALU_MUL_EN
          else if (in_valid) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
          end
`endif
        end
`ifdef SEQ_ALU_MUL_EN
        BUSY: begin
          if (count_r == CW'(WIDTH)) begin
            result   <= acc_r;
            zero     <= (acc_r == {WIDTH{1'b0}});
            negative <= acc_r[WIDTH-1];
            carry    <= 1'b0;
          end else begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
